// File: rtl/menu_nav_controller_if.sv
// Menu controller signal bundle: clap/button inputs in, page/cursor/config out.
// master: the controller; slave: the consumer (renderer, datapaths, bench).
interface menu_nav_controller_if;
   logic        clap_pulse;
   logic        btn_up;
   logic        btn_down;
   logic        btn_sel;
   logic        Menu_Clap;
   logic [1:0]  menu_state;
   logic [2:0]  cursor;
   logic [11:0] cursor_y;
   logic [1:0]  wave_sel;
   logic        axis_en;
   logic        grid_en;
   logic        ticks_en;
   logic        fft_en;
   logic        amp_en;

   modport master (
      input  clap_pulse, btn_up, btn_down, btn_sel,
      output Menu_Clap, menu_state, cursor, cursor_y, wave_sel,
      output axis_en, grid_en, ticks_en, fft_en, amp_en
   );

   modport slave (
      output clap_pulse, btn_up, btn_down, btn_sel,
      input  Menu_Clap, menu_state, cursor, cursor_y, wave_sel,
      input  axis_en, grid_en, ticks_en, fft_en, amp_en
   );
endinterface

// File: rtl/menu_nav_controller.sv
// Clap-menu sequencer on the pixel clock: debounces the three pushbuttons,
// tracks page/cursor/visibility and holds the display/analysis config bits.
// Optional MENU_AUTOHIDE_EN: hide the menu after TIMEOUT_CYCLES of inactivity.
module menu_nav_controller #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_080_000,
   parameter int unsigned TIMEOUT_CYCLES  = 1_080_000_000,
   parameter int unsigned ROW0_Y          = 864,
   parameter int unsigned ROW_PITCH       = 16
) (
   input logic                   CLK_VGA,
   input logic                   RESET,
   menu_nav_controller_if.master bus
);

   localparam int unsigned    DbW    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DbW-1:0] DbMax  = DbW'(DEBOUNCE_CYCLES);
   localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      StMain     = 2'b00,
      StWave     = 2'b01,
      StDisplay  = 2'b10,
      StAnalysis = 2'b11
   } page_e;

   // Button order within vectors: [0] up, [1] down, [2] sel.
   logic [2:0]     btn_raw;
   logic [2:0]     sync1_q, sync2_q, press_q;
   logic [DbW-1:0] db_cnt_q [3];

   assign btn_raw = {bus.btn_sel, bus.btn_down, bus.btn_up};

   // Synchronise and debounce; one pulse per press, saturation blocks auto-repeat.
   always_ff @(posedge CLK_VGA) begin
      if (RESET) begin
         sync1_q <= '0;
         sync2_q <= '0;
         press_q <= '0;
         for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
         for (int i = 0; i < 3; i++) begin
            if (!sync2_q[i]) begin
               db_cnt_q[i] <= '0;
               press_q[i]  <= 1'b0;
            end else if (db_cnt_q[i] != DbMax) begin
               db_cnt_q[i] <= db_cnt_q[i] + DbW'(1);
               press_q[i]  <= (db_cnt_q[i] == DbLast);
            end else begin
               press_q[i]  <= 1'b0;
            end
         end
      end
   end

   page_e       page_q, page_d;
   logic        vis_q, vis_d;
   logic [2:0]  cursor_q, cursor_d;
   logic [11:0] cursor_y_q, cursor_y_d;
   logic [1:0]  wave_q, wave_d;
   logic        axis_q, axis_d, grid_q, grid_d, ticks_q, ticks_d;
   logic        fft_q, fft_d, amp_q, amp_d;
   logic [2:0]  count;
   logic        accept;

   // Number of selectable items on the current page.
   always_comb begin
      count = 3'd3;
      case (page_q)
         StMain:     count = 3'd3;
         StWave:     count = 3'd5;
         StDisplay:  count = 3'd4;
         StAnalysis: count = 3'd3;
         default:    count = 3'd3;
      endcase
   end

   // A press only counts when visible, alone, and not overridden by a clap.
   assign accept = vis_q && !bus.clap_pulse && $onehot(press_q);

`ifdef MENU_AUTOHIDE_EN
   localparam int unsigned   ToW    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT_CYCLES - 1);
   logic [ToW-1:0] idle_q, idle_d;
`endif

   // Next-state for visibility, page, cursor and configuration bits.
   always_comb begin
      vis_d    = vis_q;
      page_d   = page_q;
      cursor_d = (cursor_q < count) ? cursor_q : 3'd0;
      wave_d   = wave_q;
      axis_d   = axis_q;
      grid_d   = grid_q;
      ticks_d  = ticks_q;
      fft_d    = fft_q;
      amp_d    = amp_q;

      if (bus.clap_pulse) begin
         vis_d = !vis_q;
         if (!vis_q) begin
            page_d   = StMain;
            cursor_d = 3'd0;
         end
      end else if (accept) begin
         if (press_q[0]) begin
            cursor_d = (cursor_d == 3'd0) ? count - 3'd1 : cursor_d - 3'd1;
         end else if (press_q[1]) begin
            cursor_d = (cursor_d >= count - 3'd1) ? 3'd0 : cursor_d + 3'd1;
         end else begin
            case (page_q)
               StMain: begin
                  page_d   = page_e'(cursor_d[1:0] + 2'd1);
                  cursor_d = 3'd0;
               end
               StWave: begin
                  if (cursor_d < 3'd4) begin
                     wave_d = cursor_d[1:0];
                  end else begin
                     page_d   = StMain;
                     cursor_d = 3'd0;
                  end
               end
               StDisplay: begin
                  case (cursor_d)
                     3'd0:    axis_d  = !axis_q;
                     3'd1:    grid_d  = !grid_q;
                     3'd2:    ticks_d = !ticks_q;
                     default: begin
                        page_d   = StMain;
                        cursor_d = 3'd0;
                     end
                  endcase
               end
               default: begin
                  case (cursor_d)
                     3'd0:    fft_d = !fft_q;
                     3'd1:    amp_d = !amp_q;
                     default: begin
                        page_d   = StMain;
                        cursor_d = 3'd0;
                     end
                  endcase
               end
            endcase
         end
      end

`ifdef MENU_AUTOHIDE_EN
      if (!vis_q || bus.clap_pulse || accept) begin
         idle_d = '0;
      end else if (idle_q == ToLast) begin
         idle_d   = '0;
         vis_d    = 1'b0;
         page_d   = StMain;
         cursor_d = 3'd0;
      end else begin
         idle_d = idle_q + ToW'(1);
      end
`endif

      cursor_y_d = 12'(ROW0_Y) + 12'(ROW_PITCH) * 12'(cursor_d);
   end

   // Register all menu state and outputs.
   always_ff @(posedge CLK_VGA) begin
      if (RESET) begin
         vis_q      <= 1'b0;
         page_q     <= StMain;
         cursor_q   <= 3'd0;
         cursor_y_q <= 12'(ROW0_Y);
         wave_q     <= 2'b00;
         axis_q     <= 1'b1;
         grid_q     <= 1'b1;
         ticks_q    <= 1'b1;
         fft_q      <= 1'b0;
         amp_q      <= 1'b0;
`ifdef MENU_AUTOHIDE_EN
         idle_q     <= '0;
`endif
      end else begin
         vis_q      <= vis_d;
         page_q     <= page_d;
         cursor_q   <= cursor_d;
         cursor_y_q <= cursor_y_d;
         wave_q     <= wave_d;
         axis_q     <= axis_d;
         grid_q     <= grid_d;
         ticks_q    <= ticks_d;
         fft_q      <= fft_d;
         amp_q      <= amp_d;
`ifdef MENU_AUTOHIDE_EN
         idle_q     <= idle_d;
`endif
      end
   end

   assign bus.Menu_Clap  = vis_q;
   assign bus.menu_state = page_q;
   assign bus.cursor     = cursor_q;
   assign bus.cursor_y   = cursor_y_q;
   assign bus.wave_sel   = wave_q;
   assign bus.axis_en    = axis_q;
   assign bus.grid_en    = grid_q;
   assign bus.ticks_en   = ticks_q;
   assign bus.fft_en     = fft_q;
   assign bus.amp_en     = amp_q;

endmodule

// File: tb/tb_menu_nav_controller.sv
// Bench for menu_nav_controller: directed plan steps followed by random
// button/clap sequences, all checked against a page/item reference model.
module tb_menu_nav_controller;
   localparam int unsigned Deb = 4;
   localparam int unsigned To  = 50;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   menu_nav_controller_if bus ();

   menu_nav_controller #(
      .DEBOUNCE_CYCLES (Deb),
      .TIMEOUT_CYCLES  (To),
      .ROW0_Y          (864),
      .ROW_PITCH       (16)
   ) dut (
      .CLK_VGA (clk),
      .RESET   (rst),
      .bus     (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: visibility, page index, item index, config bits.
   bit m_vis;
   int m_page, m_cur, m_wave;
   bit m_disp [3];
   bit m_an   [2];
   int item_cnt [4] = '{3, 5, 4, 3};

   task automatic m_reset();
      m_vis = 0; m_page = 0; m_cur = 0; m_wave = 0;
      m_disp = '{1, 1, 1};
      m_an   = '{0, 0};
   endtask

   task automatic m_clap();
      m_vis = !m_vis;
      if (m_vis) begin
         m_page = 0;
         m_cur  = 0;
      end
   endtask

   task automatic m_press(input int k);
      int n;
      n = item_cnt[m_page];
      if (!m_vis) return;
      if (k == 0) m_cur = (m_cur + n - 1) % n;
      else if (k == 1) m_cur = (m_cur + 1) % n;
      else begin
         case (m_page)
            0: begin m_page = m_cur + 1; m_cur = 0; end
            1: if (m_cur < 4) m_wave = m_cur; else begin m_page = 0; m_cur = 0; end
            2: if (m_cur < 3) m_disp[m_cur] = !m_disp[m_cur];
               else begin m_page = 0; m_cur = 0; end
            default: if (m_cur < 2) m_an[m_cur] = !m_an[m_cur];
                     else begin m_page = 0; m_cur = 0; end
         endcase
      end
   endtask

   task automatic m_apply(input logic [2:0] mask, input int hold);
      if ($countones(mask) == 1 && hold >= int'(Deb))
         m_press(mask[0] ? 0 : (mask[1] ? 1 : 2));
   endtask

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check(input string tag);
      cmp({tag, ".vis"},    32'(bus.Menu_Clap),  32'(m_vis));
      cmp({tag, ".page"},   32'(bus.menu_state), 32'(m_page));
      cmp({tag, ".cursor"}, 32'(bus.cursor),     32'(m_cur));
      cmp({tag, ".row_y"},  32'(bus.cursor_y),   32'(864 + 16 * m_cur));
      cmp({tag, ".wave"},   32'(bus.wave_sel),   32'(m_wave));
      cmp({tag, ".axis"},   32'(bus.axis_en),    32'(m_disp[0]));
      cmp({tag, ".grid"},   32'(bus.grid_en),    32'(m_disp[1]));
      cmp({tag, ".ticks"},  32'(bus.ticks_en),   32'(m_disp[2]));
      cmp({tag, ".fft"},    32'(bus.fft_en),     32'(m_an[0]));
      cmp({tag, ".amp"},    32'(bus.amp_en),     32'(m_an[1]));
   endtask

   task automatic drive(input logic [2:0] mask);
      bus.btn_up   = mask[0];
      bus.btn_down = mask[1];
      bus.btn_sel  = mask[2];
   endtask

   // Hold buttons for 'hold' edges, release, then let the debouncer settle.
   task automatic press(input logic [2:0] mask, input int hold);
      @(negedge clk) drive(mask);
      repeat (hold) @(posedge clk);
      @(negedge clk) drive(3'b000);
      repeat (4) @(negedge clk);
      m_apply(mask, hold);
   endtask

   task automatic clap();
      @(negedge clk) bus.clap_pulse = 1'b1;
      @(negedge clk) bus.clap_pulse = 1'b0;
      @(negedge clk);
      m_clap();
   endtask

   // Clap lands in exactly the cycle the press pulse is high.
   task automatic press_with_clap(input logic [2:0] mask);
      @(negedge clk) drive(mask);
      repeat (Deb + 2) @(posedge clk);
      @(negedge clk) begin
         drive(3'b000);
         bus.clap_pulse = 1'b1;
      end
      @(negedge clk) bus.clap_pulse = 1'b0;
      repeat (3) @(negedge clk);
      m_clap();
   endtask

   task automatic do_reset();
      @(negedge clk) rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      m_reset();
   endtask

   localparam logic [2:0] Up = 3'b001, Dn = 3'b010, Sel = 3'b100;

   initial begin
      bus.clap_pulse = 1'b0;
      drive(3'b000);
      m_reset();
      do_reset();
      repeat (20) @(negedge clk);
      check("reset");

      clap();
      check("show");
      press(Dn, 3);
      check("short_hold");
      press(Dn, 6);
      check("one_step");
      cmp("one_step.row_y_abs", 32'(bus.cursor_y), 32'd880);

      press(Up, 6);
      press(Up, 6);
      check("up_wrap");
      cmp("up_wrap.cursor_abs", 32'(bus.cursor), 32'd2);
      press(Sel, 6);
      check("to_analysis");
      press(Sel, 6);
      check("fft_toggle");
      cmp("fft_toggle.abs", 32'(bus.fft_en), 32'd1);
      press(Dn, 6);
      press(Dn, 6);
      press(Sel, 6);
      check("analysis_back");

      press(Sel, 6);
      check("to_wave");
      press(Dn, 6);
      press(Dn, 6);
      press(Sel, 6);
      check("wave_blocks");
      press(Dn, 6);
      press(Dn, 6);
      press(Sel, 6);
      check("wave_back");
      clap();
      check("hide");
      clap();
      check("reshow");
      cmp("reshow.wave_abs", 32'(bus.wave_sel), 32'd2);

      press(Up | Dn, 6);
      check("dual_press");
      press(Sel, 6);
      press_with_clap(Sel);
      check("clap_vs_sel");
      cmp("clap_vs_sel.page_abs", 32'(bus.menu_state), 32'd1);
      press(Dn, 6);
      check("hidden_press");

      // Reset while a press is one edge from being accepted.
      clap();
      press(Sel, 6);
      @(negedge clk) drive(Dn);
      repeat (Deb + 1) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(negedge clk) begin
         rst = 1'b0;
         drive(3'b000);
      end
      repeat (6) @(negedge clk);
      m_reset();
      check("mid_reset");

`ifdef MENU_AUTOHIDE_EN
      clap();
      press(Dn, 6);
      press(Sel, 6);
      press(Dn, 6);
      press(Sel, 6);
      check("display_grid");
      repeat (To + 5) @(negedge clk);
      m_vis = 0; m_page = 0; m_cur = 0;
      check("autohide");
      clap();
      for (int i = 0; i < 4; i++) begin
         press(Dn, 6);
         repeat (30) @(negedge clk);
         check("keepalive");
      end
`else
      clap();
      for (int i = 0; i < 40; i++) begin
         int r, hold;
         logic [2:0] mask;
         r    = int'($urandom_range(0, 9));
         hold = int'($urandom_range(Deb, Deb + 4));
         case (r)
            0, 1: mask = Up;
            2, 3: mask = Dn;
            4, 5: mask = Sel;
            7:    mask = Up | Dn;
            8:    begin mask = 3'b001 << $urandom_range(0, 2); hold = Deb - 1; end
            9:    mask = Dn | Sel;
            default: mask = 3'b000;
         endcase
         if (r == 6) clap();
         else press(mask, hold);
         check("random");
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
